// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and decode helper shared by the sequential ALU.
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_MUL = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_DIV = 3'd7;
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;
    function automatic logic is_multi(input logic [2:0] op);
        return op == ALU_MUL || op == ALU_DIV;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/ready operand and result bundle between the EX-stage control and the ALU.
interface alu_seq_if #(parameter int WIDTH = 16, parameter int SHW = 4);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [2:0]       i_alu_op;
    logic [SHW-1:0]   i_shamt;
    logic [WIDTH-1:0] o_result;
    logic [WIDTH-1:0] o_hi;
    logic             o_zero;
    logic             o_div_zero;
    logic             o_busy;
    logic             o_ready;
    modport master (
        output i_start, i_a, i_b, i_alu_op, i_shamt,
        input  o_result, o_hi, o_zero, o_div_zero, o_busy, o_ready
    );
    modport slave (
        input  i_start, i_a, i_b, i_alu_op, i_shamt,
        output o_result, o_hi, o_zero, o_div_zero, o_busy, o_ready
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one bit per edge unsigned shift-add multiplier and restoring divider.
// o_lo/o_hi present the next iteration's values so the caller can capture the final step on o_done.
module alu_muldiv_iter #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    // b == 0 in DIV makes every trial subtract succeed: quotient all ones, remainder a.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});
        w_sh   = {r_hi, r_lo[WIDTH-1]};
        w_ge   = w_sh >= {1'b0, r_d};
        w_diff = w_sh[WIDTH-1:0] - r_d;
        o_hi   = r_div ? (w_ge ? w_diff : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
        o_lo   = r_div ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
        o_done = r_cnt == CW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_d   <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
        end else if (i_go) begin
            r_cnt <= CW'(WIDTH);
            r_div <= i_div;
            r_d   <= i_div ? i_b : i_a;
            r_lo  <= i_div ? i_a : i_b;
            r_hi  <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_lo  <= o_lo;
            r_hi  <= o_hi;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered single-cycle ALU ops plus iterative MUL/DIV behind a start/busy/ready handshake.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input logic        clk,
    input logic        rst,
    alu_seq_if.slave   bus
);
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_go;
    logic             w_multi;
    logic             w_done;
    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_dz;
    logic             r_dz_pend;
    logic             r_ready;
    assign w_a     = bus.i_a;
    assign w_b     = bus.i_b;
    assign w_op    = bus.i_alu_op;
    assign w_sh    = bus.i_shamt;
    assign w_multi = is_multi(w_op);
    assign w_go    = bus.i_start && r_state == ST_IDLE;
    always_comb begin
        w_res = w_op == ALU_ADD ? w_a + w_b :
                w_op == ALU_SUB ? w_a - w_b :
                w_op == ALU_AND ? w_a & w_b :
                w_op == ALU_OR  ? w_a | w_b :
                w_op == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)} :
                w_op == ALU_SLL ? w_a << w_sh : '0;
    end
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .i_go   (w_go && w_multi),
        .i_div  (w_op == ALU_DIV),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_done (w_done),
        .o_lo   (w_lo),
        .o_hi   (w_hi)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_hi      <= '0;
            r_zero    <= 1'b1;
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_go) begin
                r_dz      <= 1'b0;
                r_dz_pend <= w_op == ALU_DIV && w_b == '0;
                if (w_multi) begin
                    r_state <= ST_RUN;
                end else begin
                    r_result <= w_res;
                    r_hi     <= '0;
                    r_zero   <= w_res == '0;
                    r_ready  <= 1'b1;
                end
            end else if (r_state == ST_RUN && w_done) begin
                r_state  <= ST_IDLE;
                r_result <= w_lo;
                r_hi     <= w_hi;
                r_zero   <= w_lo == '0;
                r_dz     <= r_dz_pend;
                r_ready  <= 1'b1;
            end
        end
    end
    assign bus.o_result   = r_result;
    assign bus.o_hi       = r_hi;
    assign bus.o_zero     = r_zero;
    assign bus.o_div_zero = r_dz;
    assign bus.o_busy     = r_state == ST_RUN;
    assign bus.o_ready    = r_ready;
endmodule
